// File: rtl/reg_scan_display.sv
// reg_scan_display
//   Steps through the 32 CPU registers with two push-buttons and shows the
//   selected register as 8 hex digits on a multiplexed 7-segment display.
//
// Ports
//   clk       sole clock, rising edge
//   rst       asynchronous reset, active-low
//   btn_next  raw push-button (async, active-high): select next register
//   btn_prev  raw push-button (async, active-high): select previous register
//   reg_addr  register-file debug read address ({27'b0, sel_idx})
//   reg_data  register-file debug read data
//   sel_idx   currently selected register number
//   seg       segment drive, active-low, {dp,g,f,e,d,c,b,a}
//   an        digit enables, active-low, an[k] drives hex digit k
module reg_scan_display #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [16:0] REFRESH_DIV     = 17'd100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_next,
    input  logic        btn_prev,
    output logic [31:0] reg_addr,
    input  logic [31:0] reg_data,
    output logic [4:0]  sel_idx,
    output logic [7:0]  seg,
    output logic [7:0]  an
);

    // Bit 0 carries btn_next, bit 1 carries btn_prev throughout.
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [1:0]       deb_q;
    logic [1:0][19:0] db_cnt;
    logic [1:0]       press;

    logic [31:0] data_latch;
    logic [16:0] refresh_cnt;
    logic [2:0]  digit;
    logic        refresh_wrap;
    logic [2:0]  digit_next;
    logic [3:0]  nibble;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Synchronizers and debouncers. The debounced level flips only after the
    // synchronized level has disagreed with it for DEBOUNCE_CYCLES edges in a
    // row; a single agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1  <= '0;
            sync2  <= '0;
            deb    <= '0;
            deb_q  <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= {btn_prev, btn_next};
            sync2 <= sync1;
            deb_q <= deb;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DEBOUNCE_CYCLES - 20'd1) begin
                    deb[i]    <= ~deb[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 20'd1;
                end
            end
        end
    end

    // One-cycle pulse on each rising debounced edge; releases are ignored.
    assign press = deb & ~deb_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_idx <= '0;
        end else if (press[0] && !press[1]) begin
            sel_idx <= sel_idx + 5'd1;
        end else if (press[1] && !press[0]) begin
            sel_idx <= sel_idx - 5'd1;
        end
    end

    assign reg_addr = {27'b0, sel_idx};

    always_comb begin
        refresh_wrap = (refresh_cnt == REFRESH_DIV - 17'd1);
        digit_next   = digit + 3'd1;
        nibble       = data_latch[{digit_next, 2'b00} +: 4];
    end

    // seg/an are loaded from the *next* digit on the wrap edge, so the digit
    // counter, the enable and the segment pattern all change on one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_latch  <= '0;
            refresh_cnt <= '0;
            digit       <= '0;
            an          <= 8'hFE;
            seg         <= 8'hC0;
        end else begin
            data_latch <= reg_data;
            if (refresh_wrap) begin
                refresh_cnt <= '0;
                digit       <= digit_next;
                an          <= ~(8'b1 << digit_next);
                seg         <= hex_to_seg(nibble);
            end else begin
                refresh_cnt <= refresh_cnt + 17'd1;
            end
        end
    end

endmodule
